// File: rtl/d_cache_ctrl.sv
// rtl/d_cache_ctrl.sv - direct-mapped, write-through, no-write-allocate data cache controller
// One-word lines; misses and stores freeze the pipeline until the backing memory completes.
module d_cache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Mem_r,
  input  logic                  Mem_w,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0] WData,
  input  logic                  Invalidate,
  output logic [DATA_WIDTH-1:0] RData,
  output logic                  D_Cache_Busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                  state;
  logic [LINES-1:0]        valid;
  logic                    pend_inv;
  logic [TAG_W-1:0]        tag_arr  [LINES];
  logic [DATA_WIDTH-1:0]   data_arr [LINES];

  logic [INDEX_BITS-1:0]   a_idx;
  logic [TAG_W-1:0]        a_tag;
  logic [INDEX_BITS-1:0]   m_idx;
  logic [TAG_W-1:0]        m_tag;
  logic                    a_hit;
  logic                    m_hit;
  logic                    lookup_hit;
  logic                    unused_addr_lsb;

  assign a_idx = Addr[INDEX_BITS+1:2];
  assign a_tag = Addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign m_idx = mem_addr[INDEX_BITS+1:2];
  assign m_tag = mem_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign unused_addr_lsb = ^Addr[1:0];

  assign a_hit = valid[a_idx] && (tag_arr[a_idx] == a_tag);
  assign m_hit = valid[m_idx] && (tag_arr[m_idx] == m_tag);
  // An invalidate in the lookup cycle wins over the hit it would otherwise produce.
  assign lookup_hit = a_hit && !Invalidate;

  assign RData = data_arr[a_idx];

  always_comb begin
    D_Cache_Busy = 1'b0;
    case (state)
      IDLE:             D_Cache_Busy = Mem_w || (Mem_r && !lookup_hit);
      RD_MISS, WR_THRU: D_Cache_Busy = 1'b1;
      default:          D_Cache_Busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid     <= '0;
      pend_inv  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Invalidate) valid <= '0;
          if (Mem_w) begin
            state     <= WR_THRU;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= Addr;
            mem_wdata <= WData;
          end else if (Mem_r && !lookup_hit) begin
            state    <= RD_MISS;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= Addr;
          end
        end
        RD_MISS: begin
          if (Invalidate) pend_inv <= 1'b1;
          if (mem_ready) begin
            valid[m_idx] <= 1'b1;
            state        <= DONE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
          end
        end
        WR_THRU: begin
          if (Invalidate) pend_inv <= 1'b1;
          if (mem_ready) begin
            state   <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        DONE: begin
          // A deferred invalidate lands on the DONE->IDLE edge, after the fill it overlapped.
          if (pend_inv || Invalidate) valid <= '0;
          pend_inv <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == RD_MISS && mem_ready) begin
      data_arr[m_idx] <= mem_rdata;
      tag_arr[m_idx]  <= m_tag;
    end else if (state == WR_THRU && mem_ready && m_hit) begin
      data_arr[m_idx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_d_cache_ctrl.sv
// tb/tb_d_cache_ctrl.sv - directed scoreboard bench for d_cache_ctrl
module tb_d_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Mem_r, Mem_w, Invalidate, mem_ready;
  logic [31:0] Addr, WData, mem_rdata;
  logic [31:0] RData, mem_addr, mem_wdata;
  logic        D_Cache_Busy, mem_req, mem_we;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];
  logic [31:0] tb_mem [logic [31:0]];

  d_cache_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .INDEX_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .Mem_r(Mem_r), .Mem_w(Mem_w), .Addr(Addr),
    .WData(WData), .Invalidate(Invalidate), .RData(RData),
    .D_Cache_Busy(D_Cache_Busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (tb_mem.exists(a)) return tb_mem[a];
    return 32'h0;
  endfunction

  task automatic pop_check(input string tag);
    int sz;
    logic [31:0] e;
    sz = exp_q.size();
    chk({tag, "_sb_nonempty"}, 32'(sz != 0), 32'd1);
    if (sz != 0) begin
      e = exp_q.pop_front();
      chk(tag, RData, e);
    end
  endtask

  // inv_mode: 0 none, 1 Invalidate in the lookup cycle, 2 Invalidate in the first memory cycle
  task automatic read_access(input string tag, input logic [31:0] a, input bit exp_hit,
                             input int waits, input int inv_mode);
    int busy_cnt;
    int w;
    bit done;
    exp_q.push_back(mem_val(a));
    @(negedge clk);
    Mem_r = 1'b1; Addr = a; Invalidate = (inv_mode == 1);
    #1;
    chk({tag, "_lookup_busy"}, 32'(D_Cache_Busy), 32'(!exp_hit));
    if (!D_Cache_Busy) begin
      pop_check({tag, "_hit_rdata"});
      @(negedge clk);
      Mem_r = 1'b0; Invalidate = 1'b0;
      return;
    end
    busy_cnt = 1; w = 0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      mem_ready = 1'b0; Invalidate = (inv_mode == 2 && c == 0);
      #1;
      if (!D_Cache_Busy) begin
        done = 1'b1;
        break;
      end
      busy_cnt++;
      chk({tag, "_rd_req"},  32'(mem_req), 32'd1);
      chk({tag, "_rd_we"},   32'(mem_we),  32'd0);
      chk({tag, "_rd_addr"}, mem_addr,     a);
      if (w == waits) begin
        mem_ready = 1'b1; mem_rdata = mem_val(a);
      end else begin
        w++;
      end
    end
    mem_ready = 1'b0; Invalidate = 1'b0;
    chk({tag, "_miss_done"}, 32'(done), 32'd1);
    chk({tag, "_miss_busy_cycles"}, 32'(busy_cnt), 32'(waits + 2));
    chk({tag, "_done_req"}, 32'(mem_req), 32'd0);
    pop_check({tag, "_miss_rdata"});
    @(negedge clk);
    Mem_r = 1'b0;
  endtask

  task automatic write_access(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input int waits);
    int busy_cnt;
    int w;
    bit done;
    @(negedge clk);
    Mem_w = 1'b1; Addr = a; WData = d;
    #1;
    chk({tag, "_store_busy"}, 32'(D_Cache_Busy), 32'd1);
    busy_cnt = 1; w = 0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if (!D_Cache_Busy) begin
        done = 1'b1;
        break;
      end
      busy_cnt++;
      chk({tag, "_wr_req"},   32'(mem_req), 32'd1);
      chk({tag, "_wr_we"},    32'(mem_we),  32'd1);
      chk({tag, "_wr_addr"},  mem_addr,     a);
      chk({tag, "_wr_wdata"}, mem_wdata,    d);
      if (w == waits) begin
        mem_ready = 1'b1;
        tb_mem[a] = d;
      end else begin
        w++;
      end
    end
    mem_ready = 1'b0;
    chk({tag, "_store_done"}, 32'(done), 32'd1);
    chk({tag, "_store_busy_cycles"}, 32'(busy_cnt), 32'(waits + 2));
    chk({tag, "_done_req"}, 32'(mem_req), 32'd0);
    @(negedge clk);
    Mem_w = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; Mem_r = 1'b0; Mem_w = 1'b0; Invalidate = 1'b0; mem_ready = 1'b0;
    Addr = 32'h0; WData = 32'h0; mem_rdata = 32'h0;
    tb_mem[32'h40]  = 32'hDEADBEEF;
    tb_mem[32'h440] = 32'h0BADF00D;
    tb_mem[32'h80]  = 32'h11112222;
    tb_mem[32'h84]  = 32'hA5A55A5A;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_we",  32'(mem_we),  32'd0);
    chk("reset_busy",    32'(D_Cache_Busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    read_access("first_rd", 32'h40, 1'b0, 2, 0);
    read_access("rehit", 32'h40, 1'b1, 0, 0);
    write_access("st_hit", 32'h40, 32'h12345678, 1);
    read_access("rd_after_st", 32'h40, 1'b1, 0, 0);
    read_access("line1_fill", 32'h84, 1'b0, 0, 0);
    write_access("st_uncached", 32'h80, 32'hCAFEF00D, 0);
    read_access("rd_40_still", 32'h40, 1'b1, 0, 0);
    read_access("no_alloc", 32'h80, 1'b0, 1, 0);
    read_access("conflict_440", 32'h440, 1'b0, 1, 0);
    read_access("conflict_40", 32'h40, 1'b0, 0, 0);
    read_access("line1_hit", 32'h84, 1'b1, 0, 0);

    read_access("inv_idle", 32'h40, 1'b0, 0, 1);
    read_access("inv_idle_other", 32'h84, 1'b0, 0, 0);
    read_access("inv_in_miss", 32'h440, 1'b0, 1, 2);
    read_access("after_pend_inv", 32'h440, 1'b0, 0, 0);
    read_access("after_pend_other", 32'h84, 1'b0, 0, 0);
    read_access("refilled_hit", 32'h440, 1'b1, 0, 0);

    @(negedge clk);
    Mem_r = 1'b1; Addr = 32'h80;
    #1;
    chk("rst_mid_busy", 32'(D_Cache_Busy), 32'd1);
    @(negedge clk);
    #1;
    chk("rst_mid_req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_after", 32'(mem_req), 32'd0);
    chk("rst_mid_we_after",  32'(mem_we),  32'd0);
    @(negedge clk);
    Mem_r = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    read_access("post_rst_80", 32'h80, 1'b0, 0, 0);
    read_access("post_rst_84", 32'h84, 1'b0, 0, 0);
    read_access("post_rst_hit", 32'h80, 1'b1, 0, 0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
